// File: rtl/exu_ctrl.sv
// Execute-stage sequencer around the combinational fu: latches one op, runs it for a
// class-dependent latency, captures the results and hands them on. Optional counters: EXU_PERF_CNT_EN.
module exu_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int TYPE_W   = 3,
    parameter int ALU_OP_W = 8,
    parameter int CSR_OP_W = 4,
    parameter int ALU_LAT  = 1,
    parameter int CSR_LAT  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [TYPE_W-1:0]   inst_type_i,
    input  logic [ALU_OP_W-1:0] alu_op_i,
    input  logic [CSR_OP_W-1:0] csr_op_i,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic [DATA_W-1:0]   imm_i,
    input  logic [DATA_W-1:0]   rdata1_i,
    input  logic [DATA_W-1:0]   rdata2_i,
    input  logic [DATA_W-1:0]   csr_rdata_i,
    output logic [TYPE_W-1:0]   fu_inst_type_o,
    output logic [ALU_OP_W-1:0] fu_alu_op_o,
    output logic [CSR_OP_W-1:0] fu_csr_op_o,
    output logic [ADDR_W-1:0]   fu_pc_o,
    output logic [DATA_W-1:0]   fu_imm_o,
    output logic [DATA_W-1:0]   fu_rdata1_o,
    output logic [DATA_W-1:0]   fu_rdata2_o,
    output logic [DATA_W-1:0]   fu_csr_rdata_o,
    input  logic [DATA_W-1:0]   fu_alu_result_i,
    input  logic [DATA_W-1:0]   fu_csr_wdata_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_W-1:0]   alu_result_o,
    output logic [DATA_W-1:0]   csr_wdata_o,
    output logic [ADDR_W-1:0]   pc_o,
    output logic                csr_we_o,
    output logic                busy_o
`ifdef EXU_PERF_CNT_EN
    ,
    output logic [31:0]         perf_ops_o,
    output logic [31:0]         perf_stall_o,
    output logic [31:0]         perf_csr_o
`endif
);

    localparam int MAX_LAT = (ALU_LAT > CSR_LAT) ? ALU_LAT : CSR_LAT;
    localparam int CNT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_csr_q, is_csr_d;
    logic [TYPE_W-1:0]   inst_type_q, inst_type_d;
    logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
    logic [CSR_OP_W-1:0] csr_op_q, csr_op_d;
    logic [ADDR_W-1:0]   pc_in_q, pc_in_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic [DATA_W-1:0]   rdata2_q, rdata2_d;
    logic [DATA_W-1:0]   csr_rdata_q, csr_rdata_d;
    logic [DATA_W-1:0]   alu_result_q, alu_result_d;
    logic [DATA_W-1:0]   csr_wdata_q, csr_wdata_d;
    logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
    logic                csr_we_q, csr_we_d;
    logic                accept;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_csr_d     = is_csr_q;
        inst_type_d  = inst_type_q;
        alu_op_d     = alu_op_q;
        csr_op_d     = csr_op_q;
        pc_in_d      = pc_in_q;
        imm_d        = imm_q;
        rdata1_d     = rdata1_q;
        rdata2_d     = rdata2_q;
        csr_rdata_d  = csr_rdata_q;
        alu_result_d = alu_result_q;
        csr_wdata_d  = csr_wdata_q;
        pc_out_d     = pc_out_q;
        csr_we_d     = 1'b0;

        in_ready_o = ((state_q == IDLE) || ((state_q == DONE) && out_ready_i)) && !flush_i;
        accept     = in_valid_i && in_ready_o;

        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        alu_result_d = fu_alu_result_i;
                        csr_wdata_d  = fu_csr_wdata_i;
                        pc_out_d     = pc_in_q;
                        csr_we_d     = is_csr_q;
                        state_d      = DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) state_d = IDLE;
                end
                default: ;
            endcase

            // A DONE-cycle accept overrides the IDLE return for zero-bubble issue.
            if (accept) begin
                inst_type_d = inst_type_i;
                alu_op_d    = alu_op_i;
                csr_op_d    = csr_op_i;
                pc_in_d     = pc_i;
                imm_d       = imm_i;
                rdata1_d    = rdata1_i;
                rdata2_d    = rdata2_i;
                csr_rdata_d = csr_rdata_i;
                is_csr_d    = (csr_op_i != '0);
                cnt_d       = (csr_op_i != '0) ? CNT_W'(CSR_LAT - 1) : CNT_W'(ALU_LAT - 1);
                state_d     = EXEC;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            is_csr_q     <= 1'b0;
            inst_type_q  <= '0;
            alu_op_q     <= '0;
            csr_op_q     <= '0;
            pc_in_q      <= '0;
            imm_q        <= '0;
            rdata1_q     <= '0;
            rdata2_q     <= '0;
            csr_rdata_q  <= '0;
            alu_result_q <= '0;
            csr_wdata_q  <= '0;
            pc_out_q     <= '0;
            csr_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_csr_q     <= is_csr_d;
            inst_type_q  <= inst_type_d;
            alu_op_q     <= alu_op_d;
            csr_op_q     <= csr_op_d;
            pc_in_q      <= pc_in_d;
            imm_q        <= imm_d;
            rdata1_q     <= rdata1_d;
            rdata2_q     <= rdata2_d;
            csr_rdata_q  <= csr_rdata_d;
            alu_result_q <= alu_result_d;
            csr_wdata_q  <= csr_wdata_d;
            pc_out_q     <= pc_out_d;
            csr_we_q     <= csr_we_d;
        end
    end

    assign fu_inst_type_o = inst_type_q;
    assign fu_alu_op_o    = alu_op_q;
    assign fu_csr_op_o    = csr_op_q;
    assign fu_pc_o        = pc_in_q;
    assign fu_imm_o       = imm_q;
    assign fu_rdata1_o    = rdata1_q;
    assign fu_rdata2_o    = rdata2_q;
    assign fu_csr_rdata_o = csr_rdata_q;
    assign alu_result_o   = alu_result_q;
    assign csr_wdata_o    = csr_wdata_q;
    assign pc_o           = pc_out_q;
    assign csr_we_o       = csr_we_q;
    assign out_valid_o    = (state_q == DONE);
    assign busy_o         = (state_q != IDLE);

`ifdef EXU_PERF_CNT_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_csr_q, perf_csr_d;

    // Counters keep running through flush; only reset clears them.
    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        perf_csr_d   = perf_csr_q;
        if (state_q == DONE) begin
            if (out_ready_i) perf_ops_d = perf_ops_q + 32'd1;
            else             perf_stall_d = perf_stall_q + 32'd1;
        end
        if (csr_we_q) perf_csr_d = perf_csr_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
            perf_csr_q   <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
            perf_csr_q   <= perf_csr_d;
        end
    end

    assign perf_ops_o   = perf_ops_q;
    assign perf_stall_o = perf_stall_q;
    assign perf_csr_o   = perf_csr_q;
`endif

endmodule

// File: tb/tb_exu_ctrl.sv
// Self-checking bench for exu_ctrl: timing checks per scenario task plus a result
// scoreboard filled on input handshakes and drained on output handshakes.
module tb_exu_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  inst_type_i;
    logic [7:0]  alu_op_i;
    logic [3:0]  csr_op_i;
    logic [31:0] pc_i, imm_i, rdata1_i, rdata2_i, csr_rdata_i;
    logic [2:0]  fu_inst_type_o;
    logic [7:0]  fu_alu_op_o;
    logic [3:0]  fu_csr_op_o;
    logic [31:0] fu_pc_o, fu_imm_o, fu_rdata1_o, fu_rdata2_o, fu_csr_rdata_o;
    logic [31:0] fu_alu_result_i, fu_csr_wdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] alu_result_o, csr_wdata_o, pc_o;
    logic        csr_we_o;
    logic        busy_o;
`ifdef EXU_PERF_CNT_EN
    logic [31:0] perf_ops_o, perf_stall_o, perf_csr_o;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] csr;
        logic [31:0] pc;
    } exp_t;
    exp_t sb[$];

    exu_ctrl dut (
        .clock(clock), .reset(reset), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .inst_type_i(inst_type_i), .alu_op_i(alu_op_i), .csr_op_i(csr_op_i),
        .pc_i(pc_i), .imm_i(imm_i), .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
        .csr_rdata_i(csr_rdata_i),
        .fu_inst_type_o(fu_inst_type_o), .fu_alu_op_o(fu_alu_op_o),
        .fu_csr_op_o(fu_csr_op_o), .fu_pc_o(fu_pc_o), .fu_imm_o(fu_imm_o),
        .fu_rdata1_o(fu_rdata1_o), .fu_rdata2_o(fu_rdata2_o),
        .fu_csr_rdata_o(fu_csr_rdata_o),
        .fu_alu_result_i(fu_alu_result_i), .fu_csr_wdata_i(fu_csr_wdata_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .alu_result_o(alu_result_o), .csr_wdata_o(csr_wdata_o), .pc_o(pc_o),
        .csr_we_o(csr_we_o), .busy_o(busy_o)
`ifdef EXU_PERF_CNT_EN
        , .perf_ops_o(perf_ops_o), .perf_stall_o(perf_stall_o), .perf_csr_o(perf_csr_o)
`endif
    );

    // Stand-in fu: simple add for ALU result, OR for CSR write data.
    assign fu_alu_result_i = fu_rdata1_o + fu_rdata2_o;
    assign fu_csr_wdata_i  = fu_csr_rdata_o | fu_rdata1_o;

    always #5 clock = ~clock;

    // Scoreboard monitor: sampled mid-cycle, when inputs and handshake signals are settled.
    always @(negedge clock) begin
        if (!reset && in_valid_i === 1'b1 && in_ready_o === 1'b1)
            sb.push_back('{alu: rdata1_i + rdata2_i, csr: csr_rdata_i | rdata1_i, pc: pc_i});
        if (!reset && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected_output: got alu=%h, expected no output", alu_result_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (alu_result_o !== e.alu || csr_wdata_o !== e.csr || pc_o !== e.pc) begin
                    errors++;
                    $display("[TB] FAIL sb_result: got alu=%h csr=%h pc=%h, expected alu=%h csr=%h pc=%h",
                             alu_result_o, csr_wdata_o, pc_o, e.alu, e.csr, e.pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_op(input logic v, input logic [3:0] cop, input logic [31:0] pc,
                            input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] crd);
        in_valid_i  = v;
        csr_op_i    = cop;
        pc_i        = pc;
        rdata1_i    = r1;
        rdata2_i    = r2;
        csr_rdata_i = crd;
        inst_type_i = 3'd1;
        alu_op_i    = 8'h3;
        imm_i       = 32'h55;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || csr_we_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got valid=%b busy=%b we=%b, expected 0 0 0", out_valid_o, busy_o, csr_we_o);
        end
        checks++;
        if (alu_result_o !== 32'h0 || csr_wdata_o !== 32'h0 || pc_o !== 32'h0 || fu_rdata1_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_regs: got alu=%h csr=%h pc=%h r1=%h, expected all 0", alu_result_o, csr_wdata_o, pc_o, fu_rdata1_o);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b, expected 1", in_ready_o);
        end
    endtask

    task automatic test_alu_op();
        out_ready_i = 1'b1;
        drive_op(1'b1, 4'd0, 32'h100, 32'd5, 32'd7, 32'h0);
        #1;
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alu_accept: in_ready got %b, expected 1", in_ready_o);
        end
        step();
        in_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b1 || fu_rdata1_o !== 32'd5 || fu_rdata2_o !== 32'd7) begin
            errors++;
            $display("[TB] FAIL alu_exec: got valid=%b busy=%b r1=%0d r2=%0d, expected 0 1 5 7", out_valid_o, busy_o, fu_rdata1_o, fu_rdata2_o);
        end
        step();
        checks++;
        if (out_valid_o !== 1'b1 || alu_result_o !== 32'd12 || csr_we_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alu_done: got valid=%b alu=%0d we=%b, expected 1 12 0", out_valid_o, alu_result_o, csr_we_o);
        end
        step();
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alu_idle: got valid=%b busy=%b, expected 0 0", out_valid_o, busy_o);
        end
    endtask

    task automatic test_csr_op();
        out_ready_i = 1'b1;
        drive_op(1'b1, 4'd1, 32'h200, 32'h0800, 32'h1, 32'h1000);
        step();
        in_valid_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (out_valid_o !== (c == 3) || csr_we_o !== (c == 3)) begin
                errors++;
                $display("[TB] FAIL csr_timing c%0d: got valid=%b we=%b, expected %b %b", c, out_valid_o, csr_we_o, c == 3, c == 3);
            end
            if (c == 3) begin
                checks++;
                if (csr_wdata_o !== 32'h1800 || pc_o !== 32'h200) begin
                    errors++;
                    $display("[TB] FAIL csr_data: got wdata=%h pc=%h, expected 1800 200", csr_wdata_o, pc_o);
                end
            end
            step();
        end
    endtask

    task automatic test_stall();
        out_ready_i = 1'b0;
        drive_op(1'b1, 4'd2, 32'h300, 32'h0042, 32'h2, 32'h0f00);
        step();
        step();
        step();
        // Cycles 3..6 are the stalled DONE cycles; a pending op is offered throughout.
        drive_op(1'b1, 4'd0, 32'h304, 32'd1, 32'd1, 32'h0);
        for (int c = 3; c <= 6; c++) begin
            #1;
            checks++;
            if (out_valid_o !== 1'b1 || csr_we_o !== (c == 3) || in_ready_o !== 1'b0
                || csr_wdata_o !== 32'h0f42 || pc_o !== 32'h300) begin
                errors++;
                $display("[TB] FAIL stall c%0d: got valid=%b we=%b rdy=%b wdata=%h pc=%h, expected 1 %b 0 0f42 300",
                         c, out_valid_o, csr_we_o, in_ready_o, csr_wdata_o, pc_o, c == 3);
            end
            step();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        #1;
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release: in_ready got %b, expected 1", in_ready_o);
        end
        step();
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_idle: got valid=%b busy=%b, expected 0 0", out_valid_o, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        out_ready_i = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            k = (c + 1) / 2;
            if (k <= 2) drive_op(1'b1, 4'd0, 32'h400 + 32'(4 * k), 32'(10 * k + 1), 32'(k + 100), 32'h0);
            else        in_valid_i = 1'b0;
            #1;
            checks++;
            if (out_valid_o !== (c == 2 || c == 4 || c == 6) || busy_o !== (c >= 1 && c <= 6)) begin
                errors++;
                $display("[TB] FAIL b2b c%0d: got valid=%b busy=%b, expected %b %b", c, out_valid_o, busy_o,
                         c == 2 || c == 4 || c == 6, c >= 1 && c <= 6);
            end
            if (c == 2 || c == 4) begin
                checks++;
                if (in_ready_o !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_ready c%0d: got %b, expected 1", c, in_ready_o);
                end
            end
            step();
        end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b1;
        drive_op(1'b1, 4'd3, 32'h500, 32'h1, 32'h2, 32'h4);
        step();
        in_valid_i = 1'b0;
        flush_i    = 1'b1;
        step();
        flush_i = 1'b0;
        sb.delete();
        for (int c = 2; c <= 5; c++) begin
            checks++;
            if (out_valid_o !== 1'b0 || csr_we_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL flush c%0d: got valid=%b we=%b busy=%b, expected 0 0 0", c, out_valid_o, csr_we_o, busy_o);
            end
            step();
        end
        drive_op(1'b1, 4'd0, 32'h600, 32'd20, 32'd22, 32'h0);
        flush_i = 1'b1;
        #1;
        checks++;
        if (in_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_ready: got %b, expected 0", in_ready_o);
        end
        step();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_noaccept: busy got %b, expected 0", busy_o);
        end
        flush_i = 1'b0;
        step();
        in_valid_i = 1'b0;
        step();
        checks++;
        if (out_valid_o !== 1'b1 || alu_result_o !== 32'd42 || pc_o !== 32'h600) begin
            errors++;
            $display("[TB] FAIL flush_next: got valid=%b alu=%0d pc=%h, expected 1 42 600", out_valid_o, alu_result_o, pc_o);
        end
        step();
    endtask

    task automatic test_reset_in_done();
        out_ready_i = 1'b0;
        drive_op(1'b1, 4'd0, 32'h700, 32'd3, 32'd4, 32'h0);
        step();
        in_valid_i = 1'b0;
        step();
        checks++;
        if (out_valid_o !== 1'b1 || alu_result_o !== 32'd7) begin
            errors++;
            $display("[TB] FAIL rst_done_pre: got valid=%b alu=%0d, expected 1 7", out_valid_o, alu_result_o);
        end
        reset = 1'b1;
        step();
        sb.delete();
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || csr_we_o !== 1'b0 || alu_result_o !== 32'h0
            || pc_o !== 32'h0 || csr_wdata_o !== 32'h0 || fu_rdata1_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_done: got valid=%b busy=%b we=%b alu=%h pc=%h r1=%h, expected all 0",
                     out_valid_o, busy_o, csr_we_o, alu_result_o, pc_o, fu_rdata1_o);
        end
`ifdef EXU_PERF_CNT_EN
        checks++;
        if (perf_ops_o !== 32'h0 || perf_stall_o !== 32'h0 || perf_csr_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_perf: got ops=%0d stall=%0d csr=%0d, expected 0 0 0", perf_ops_o, perf_stall_o, perf_csr_o);
        end
`endif
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_ready: got %b, expected 1", in_ready_o);
        end
        step();
    endtask

    initial begin
        reset       = 1'b1;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        drive_op(1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        test_reset();
        test_alu_op();
        test_csr_op();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_in_done();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain: got %0d pending results, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
